// File: rtl/i2c_master_n.sv
// Byte-write I2C/SCCB master: push-pull SCL, open-drain SDA, up to NBYTES per burst.
// Define I2C_NACK_ABORT_EN to abort into STOP on a NACK; otherwise all bytes are sent.
module i2c_master_n #(
    parameter int CLK_DIV = 63,
    parameter int NBYTES  = 3
) (
    input  logic                meg25,
    input  logic                rst_n,
    input  logic                sendit,
    input  logic [8*NBYTES-1:0] send_dat,
    input  logic [2:0]          send_len,
    output logic                scl,
    inout  wire                 sda,
    output logic                ack,
    output logic                done,
    output logic                busy,
    output logic [6:0]          send_count_out,
    output logic                nack_err
);

    localparam int         SW       = 8 * NBYTES;
    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [2:0] NB       = 3'(NBYTES);

`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACKS,
        STOP,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [2:0]      len_q, len_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic            nerr_q, nerr_d;
    logic [9:0]      div_q, div_d;
    logic            sendit_q;
    logic            tick;
    logic            start_edge;
    logic            sda_oe;

    assign tick       = (state_q != IDLE) && (div_q == DIV_LAST);
    assign start_edge = sendit && !sendit_q;

    always_ff @(posedge meg25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            qtr_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            len_q    <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            nerr_q   <= 1'b0;
            div_q    <= '0;
            // Seeded high so a level held through reset is not an edge
            sendit_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            len_q    <= len_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            nerr_q   <= nerr_d;
            div_q    <= div_d;
            sendit_q <= sendit;
        end
    end

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        len_d   = len_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        nerr_d  = nerr_q;
        div_d   = (state_q == IDLE || tick) ? 10'd0 : div_q + 10'd1;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    sh_d   = send_dat;
                    len_d  = (send_len > NB) ? NB : send_len;
                    cnt_d  = '0;
                    nerr_d = 1'b0;
                    ack_d  = 1'b0;
                    bit_d  = '0;
                    byte_d = '0;
                    qtr_d  = '0;
                    state_d = (send_len == 3'd0) ? DONE : START;
                end
            end
            START: begin
                if (tick) begin
                    if (qtr_q == 2'd0) begin
                        qtr_d = 2'd1;
                    end else begin
                        qtr_d   = 2'd0;
                        state_d = DATA;
                    end
                end
            end
            DATA, ACKS: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd0 && cnt_q != 7'd127)
                        cnt_d = cnt_q + 7'd1;
                    if (qtr_q == 2'd1 && state_q == ACKS) begin
                        ack_d = ~sda;
                        if (sda)
                            nerr_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        if (state_q == DATA) begin
                            sh_d  = sh_q << 1;
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7)
                                state_d = ACKS;
                        end else begin
                            byte_d = byte_q + 3'd1;
                            // ack_q already holds this slot's sample
                            if ((ABORT && !ack_q) || (byte_q + 3'd1 == len_q))
                                state_d = STOP;
                            else
                                state_d = DATA;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d   = 2'd0;
                        state_d = DONE;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        unique case (state_q)
            START: begin
                sda_oe = 1'b1;
                scl    = (qtr_q == 2'd0);
            end
            DATA: begin
                scl    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_oe = ~sh_q[SW-1];
            end
            ACKS: begin
                scl = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            end
            STOP: begin
                scl    = (qtr_q != 2'd0);
                sda_oe = (qtr_q != 2'd2);
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign sda            = sda_oe ? 1'b0 : 1'bz;
    assign done           = (state_q == DONE);
    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign ack            = ack_q;
    assign nack_err       = nerr_q;
    assign send_count_out = cnt_q;

endmodule

// File: tb/tb_i2c_master_n.sv
// Directed bench for i2c_master_n with a small I2C slave model.
module tb_i2c_master_n;

    localparam int NB = 3;

    logic          clk;
    logic          rst_n;
    logic          sendit;
    logic [23:0]   send_dat;
    logic [2:0]    send_len;
    logic          scl;
    wire           sda;
    logic          ack;
    logic          done;
    logic          busy;
    logic [6:0]    send_count_out;
    logic          nack_err;

    int checks = 0;
    int errors = 0;

    i2c_master_n #(.CLK_DIV(4), .NBYTES(NB)) dut (
        .meg25(clk),
        .rst_n(rst_n),
        .sendit(sendit),
        .send_dat(send_dat),
        .send_len(send_len),
        .scl(scl),
        .sda(sda),
        .ack(ack),
        .done(done),
        .busy(busy),
        .send_count_out(send_count_out),
        .nack_err(nack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave model
    logic       slv_clr = 1'b0;
    logic       slv_drv = 1'b0;
    logic [7:0] slv_nack = 8'h00;
    int         pulse_cnt = 0;
    logic       rx_bits[$];
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         done_cnt = 0;

    assign sda = slv_drv ? 1'b0 : 1'bz;
    pullup (sda);

    always @(posedge scl or negedge scl or posedge slv_clr) begin
        int bi;
        if (slv_clr) begin
            pulse_cnt = 0;
            rx_bits.delete();
            slv_drv = 1'b0;
        end else if (scl === 1'b1) begin
            rx_bits.push_back((sda === 1'b0) ? 1'b0 : 1'b1);
            pulse_cnt++;
        end else if (pulse_cnt % 9 == 8) begin
            bi = pulse_cnt / 9;
            slv_drv = !slv_nack[bi[2:0]];
        end else begin
            slv_drv = 1'b0;
        end
    end

    always @(posedge sda or negedge sda or posedge slv_clr) begin
        if (slv_clr) begin
            start_cnt = 0;
            stop_cnt = 0;
        end else if (scl === 1'b1) begin
            if (sda === 1'b0) start_cnt++;
            else stop_cnt++;
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [2:0]  len;
        logic [23:0] dat;
        logic [7:0]  nack;
        int          exp_cnt;
        logic        exp_ack;
        logic        exp_nerr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic slave_clear(input logic [7:0] mask);
        slv_nack = mask;
        slv_clr = 1'b1;
        #1;
        slv_clr = 1'b0;
    endtask

    task automatic start_txn(input logic [2:0] len, input logic [23:0] dat,
                             input bit hold);
        @(negedge clk);
        send_len = len;
        send_dat = dat;
        sendit = 1'b1;
        @(negedge clk);
        if (!hold) sendit = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic check_bits(input logic [23:0] dat, input logic [7:0] nack,
                              input int n);
        int bad;
        int b;
        int p;
        logic e;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            b = k / 9;
            p = k % 9;
            if (p < 8) e = dat[23 - 8 * b - p];
            else e = nack[b[2:0]];
            if (k >= rx_bits.size() || rx_bits[k] !== e) bad++;
        end
        chk("bit_seq", bad, 0);
    endtask

    int cyc;
    int dc0;

    initial begin
        rst_n = 1'b0;
        sendit = 1'b1;
        send_dat = 24'h0;
        send_len = 3'd0;

        // reset state, sendit held high across reset release
        #23;
        chk("rst_scl", int'(scl), 1);
        chk("rst_sda", int'(sda === 1'b1), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_nerr", int'(nack_err), 0);
        chk("rst_cnt", int'(send_count_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_start_held", int'(busy || done), 0);
        sendit = 1'b0;
        repeat (2) @(negedge clk);

        vecs[0] = '{3'd3, 24'hFF_FF_FF, 8'h00, 27, 1'b1, 1'b0};
        vecs[1] = '{3'd2, 24'h42_A5_00, 8'h00, 18, 1'b1, 1'b0};
`ifdef I2C_NACK_ABORT_EN
        vecs[2] = '{3'd3, 24'h5A_C3_0F, 8'h01, 9, 1'b0, 1'b1};
        vecs[3] = '{3'd3, 24'h81_7E_33, 8'h02, 18, 1'b0, 1'b1};
`else
        vecs[2] = '{3'd3, 24'h5A_C3_0F, 8'h01, 27, 1'b1, 1'b1};
        vecs[3] = '{3'd3, 24'h81_7E_33, 8'h02, 27, 1'b1, 1'b1};
`endif
        vecs[4] = '{3'd7, 24'h12_34_56, 8'h00, 27, 1'b1, 1'b0};
        vecs[5] = '{3'd1, 24'hA5_00_00, 8'h00, 9, 1'b1, 1'b0};
        vecs[6] = '{3'd3, 24'h00_00_00, 8'h04, 27, 1'b0, 1'b1};

        for (int i = 0; i < 7; i++) begin
            slave_clear(vecs[i].nack);
            start_txn(vecs[i].len, vecs[i].dat, 1'b0);
            chk("busy_run", int'(busy), 1);
            wait_done(cyc);
            chk("busy_at_done", int'(busy), 0);
            @(negedge clk);
            chk("done_width", int'(done), 0);
            chk("count", int'(send_count_out), vecs[i].exp_cnt);
            chk("ack", int'(ack), int'(vecs[i].exp_ack));
            chk("nack_err", int'(nack_err), int'(vecs[i].exp_nerr));
            chk("scl_pulses", rx_bits.size(), vecs[i].exp_cnt + 1);
            check_bits(vecs[i].dat, vecs[i].nack, vecs[i].exp_cnt);
            chk("start_cond", start_cnt, 1);
            chk("stop_cond", stop_cnt, 1);
            chk("idle_scl", int'(scl), 1);
            chk("idle_sda", int'(sda === 1'b1), 1);
        end

        // zero-length request
        slave_clear(8'h00);
        start_txn(3'd0, 24'hFF_00_FF, 1'b0);
        wait_done(cyc);
        chk("len0_latency", int'(cyc <= 2), 1);
        @(negedge clk);
        chk("len0_done_width", int'(done), 0);
        chk("len0_count", int'(send_count_out), 0);
        chk("len0_pulses", rx_bits.size(), 0);
        chk("len0_bus", start_cnt + stop_cnt, 0);

        // sendit held high through done
        slave_clear(8'h00);
        dc0 = done_cnt;
        start_txn(3'd1, 24'hA5_00_00, 1'b1);
        wait_done(cyc);
        repeat (300) @(negedge clk);
        chk("held_one_txn", done_cnt - dc0, 1);
        chk("held_busy", int'(busy), 0);
        sendit = 1'b0;
        @(negedge clk);

        // re-pulse while busy, with changed inputs
        slave_clear(8'h00);
        dc0 = done_cnt;
        start_txn(3'd2, 24'h42_A5_00, 1'b0);
        repeat (40) @(negedge clk);
        send_len = 3'd3;
        send_dat = 24'h00_00_00;
        sendit = 1'b1;
        @(negedge clk);
        sendit = 1'b0;
        wait_done(cyc);
        repeat (300) @(negedge clk);
        chk("repulse_one_txn", done_cnt - dc0, 1);
        chk("repulse_count", int'(send_count_out), 18);
        check_bits(24'h42_A5_00, 8'h00, 18);

        // reset mid-byte
        slave_clear(8'h00);
        start_txn(3'd3, 24'hFF_FF_FF, 1'b0);
        cyc = 0;
        while (pulse_cnt < 3 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midbyte_reached", int'(pulse_cnt >= 3), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_scl", int'(scl), 1);
        chk("arst_sda", int'(sda === 1'b1), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cnt", int'(send_count_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        slave_clear(8'h00);
        start_txn(3'd3, 24'hFF_FF_FF, 1'b0);
        wait_done(cyc);
        @(negedge clk);
        chk("post_rst_count", int'(send_count_out), 27);
        chk("post_rst_ack", int'(ack), 1);
        chk("post_rst_nerr", int'(nack_err), 0);
        check_bits(24'hFF_FF_FF, 8'h00, 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
